hi_sim_sched: RTL and testbench
===============================

HI_SIM_SCHED -- requirements
Module: hi_sim_sched

Interface
REQ-001 Parameter EOF_GAP, default 512: carrier cycles without a reader pause that end a reader frame.
REQ-002 Parameter BIT_CYC, default 128: carrier cycles per response bit (fc/128, 106 kbit/s).
REQ-003 ck_1356meg  in  1  13.56 MHz carrier clock; sole clock; all state on posedge.
REQ-004 nrst  in  1  reset; asynchronous assert, active-low.
REQ-005 reader_pause  in  1  comparator output; 1 = reader field paused. Already synchronised to ck_1356meg.
REQ-006 arm_ready  in  1  ARM has a response loaded; level, sampled at FDT expiry.
REQ-007 arm_mod_type  in  3  modulation to use for the response: 000 none, 001 BPSK, 010 212k, 100 424k, 101 424k-8bit.
REQ-008 fdt  in  12  frame delay time in carrier cycles, measured from the end of the last pause.
REQ-009 tx_bits  in  10  response length in bits; 0 = no response.
REQ-010 mod_type  out  3  drives the tag-simulation modulator; 000 whenever not in TX.
REQ-011 tx_active  out  1  high exactly while in TX.
REQ-012 rx_done  out  1  one-cycle pulse when a reader frame ends.
REQ-013 missed  out  1  sticky; response not ready at FDT expiry.
REQ-014 collided  out  1  sticky; reader pause seen during TX.
REQ-015 clr_flags  in  1  synchronous clear of missed and collided; set wins if same cycle.

Function
REQ-016 States: IDLE, RX, WAIT_FDT, TX; exactly one active.
REQ-017 IDLE: reader_pause=1 -> RX; gap counter cleared.
REQ-018 RX: gap counter counts cycles with reader_pause=0 and clears on any reader_pause=1. Reaching EOF_GAP-1 -> WAIT_FDT, with rx_done pulsed that cycle.
REQ-019 FDT counter starts at 0 on the first reader_pause=0 cycle after the last pause, i.e. rising edge of pause end. It runs through RX and WAIT_FDT.
REQ-020 WAIT_FDT: reader_pause=1 -> RX, with FDT and gap counters cleared; new frame, no response.
REQ-021 WAIT_FDT: FDT counter == fdt-1 -> FDT expiry.
REQ-022 At FDT expiry: arm_ready=1 and tx_bits!=0 -> TX next cycle.
REQ-023 At FDT expiry: arm_ready=0 -> IDLE, missed set.
REQ-024 At FDT expiry: arm_ready=1 and tx_bits=0 -> IDLE, no flag.
REQ-025 fdt smaller than EOF_GAP: expiry occurs on entry to WAIT_FDT, i.e. the FDT is extended, not skipped.
REQ-026 arm_mod_type and tx_bits are latched on TX entry; later changes are ignored until the next TX.
REQ-027 TX: mod_type = latched type; tx_active=1. Bit counter advances every BIT_CYC cycles.
REQ-028 TX lasts exactly tx_bits*BIT_CYC cycles, then -> IDLE with mod_type=000 the next cycle.
REQ-029 TX: reader_pause=1 -> RX immediately, collided set, mod_type=000 next cycle.
REQ-030 Latched arm_mod_type not in the legal set -> TX is still timed, but mod_type=000.
REQ-031 Counters are wide enough that they never wrap within a legal operation: gap 10 bits, FDT 12 bits, TX 17 bits.
REQ-032 mod_type, tx_active and rx_done are registered outputs, with no combinational path from inputs.

Reset
REQ-033 nrst=0: state IDLE, all counters 0, mod_type=000, tx_active=0, rx_done=0, missed=0, collided=0. Effect is immediate and independent of the clock.
REQ-034 nrst asserted mid-TX: mod_type returns to 000 asynchronously. First cycle after release is in IDLE.

Verification
REQ-035 Test 1, normal response:
- Stimulus: pause 40 cycles, then idle; fdt=1172, tx_bits=4, arm_ready=1, type 100.
- Response: rx_done at cycle 511 after pause end; TX entered at cycle 1172; mod_type=100 for exactly 512 cycles; then 000.
REQ-036 Test 2, not ready: as Test 1 with arm_ready=0 -> no TX, missed=1, state IDLE.
REQ-037 Test 3, pause during WAIT_FDT: pause again at cycle 800 after the first pause end -> back to RX, no TX. The FDT restarts from the second pause end.
REQ-038 Test 4, collision: reader_pause=1 at TX bit 2 -> collided=1, mod_type=000 within 1 cycle, state RX.
REQ-039 Test 5, edge cases:
- fdt=100 (< EOF_GAP) -> TX starts on the cycle after rx_done.
- tx_bits=0 -> no TX, no flag.
REQ-040 Test 6, reset and clear:
- nrst pulsed mid-TX -> all outputs 0 at once.
- clr_flags asserted the same cycle as a collision -> collided=1.

Source files
------------

// File: rtl/hi_sim_sched.sv
// ISO14443-A tag-simulation scheduler: detects the end of a reader frame, times the
// frame delay, then plays the ARM's response as a modulation window on the carrier.
module hi_sim_sched #(
    parameter int EOF_GAP = 512,
    parameter int BIT_CYC = 128
) (
    input  logic        ck_1356meg,
    input  logic        nrst,
    input  logic        reader_pause,
    input  logic        arm_ready,
    input  logic [2:0]  arm_mod_type,
    input  logic [11:0] fdt,
    input  logic [9:0]  tx_bits,
    input  logic        clr_flags,
    output logic [2:0]  mod_type,
    output logic        tx_active,
    output logic        rx_done,
    output logic        missed,
    output logic        collided
);

    localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [9:0]       GAP_LAST = 10'(EOF_GAP - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_WAIT = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        gap_q, gap_d;
    logic [11:0]       fdt_cnt_q, fdt_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [9:0]        bit_q, bit_d;
    logic [2:0]        type_q, type_d;
    logic [9:0]        bits_q, bits_d;
    logic [2:0]        mod_type_q, mod_type_d;
    logic              tx_active_q, tx_active_d;
    logic              rx_done_q, rx_done_d;
    logic              missed_q, missed_d;
    logic              collided_q, collided_d;

    logic              rx_pulse_s, miss_set_s, coll_set_s;
    logic [11:0]       fdt_inc_s;
    logic              fdt_expired_s;

    function automatic logic mod_legal(input logic [2:0] t);
        logic ok;
        case (t)
            3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A short fdt expires on the first WAIT cycle, so the delay is stretched rather than lost.
    assign fdt_inc_s     = (fdt_cnt_q == 12'hFFF) ? fdt_cnt_q : fdt_cnt_q + 12'd1;
    assign fdt_expired_s = ({1'b0, fdt_cnt_q} + 13'd1) >= {1'b0, fdt};

    // State register and all counters / latched response parameters.
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            gap_q       <= 10'd0;
            fdt_cnt_q   <= 12'd0;
            cyc_q       <= '0;
            bit_q       <= 10'd0;
            type_q      <= 3'b000;
            bits_q      <= 10'd0;
            mod_type_q  <= 3'b000;
            tx_active_q <= 1'b0;
            rx_done_q   <= 1'b0;
            missed_q    <= 1'b0;
            collided_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            fdt_cnt_q   <= fdt_cnt_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            type_q      <= type_d;
            bits_q      <= bits_d;
            mod_type_q  <= mod_type_d;
            tx_active_q <= tx_active_d;
            rx_done_q   <= rx_done_d;
            missed_q    <= missed_d;
            collided_q  <= collided_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        fdt_cnt_d  = fdt_cnt_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        type_d     = type_q;
        bits_d     = bits_q;
        rx_pulse_s = 1'b0;
        miss_set_s = 1'b0;
        coll_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reader_pause) begin
                    state_d   = ST_RX;
                    gap_d     = 10'd0;
                    fdt_cnt_d = 12'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX: begin
                if (reader_pause) begin
                    gap_d     = 10'd0;
                    fdt_cnt_d = 12'd0;
                end else begin
                    fdt_cnt_d = fdt_inc_s;
                    if (gap_q == GAP_LAST) begin
                        state_d    = ST_WAIT;
                        rx_pulse_s = 1'b1;
                    end else begin
                        gap_d = gap_q + 10'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (reader_pause) begin
                    state_d   = ST_RX;
                    gap_d     = 10'd0;
                    fdt_cnt_d = 12'd0;
                end else begin
                    fdt_cnt_d = fdt_inc_s;
                    if (fdt_expired_s) begin
                        if (!arm_ready) begin
                            state_d    = ST_IDLE;
                            miss_set_s = 1'b1;
                        end else if (tx_bits == 10'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_TX;
                            type_d  = arm_mod_type;
                            bits_d  = tx_bits;
                            cyc_d   = '0;
                            bit_d   = 10'd0;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_TX: begin
                if (reader_pause) begin
                    state_d    = ST_RX;
                    coll_set_s = 1'b1;
                    gap_d      = 10'd0;
                    fdt_cnt_d  = 12'd0;
                end else if (cyc_q == CYC_LAST) begin
                    if (bit_q == bits_q - 10'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 10'd1;
                        cyc_d = '0;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they align with it.
    always_comb begin
        mod_type_d  = 3'b000;
        tx_active_d = 1'b0;
        if (state_d == ST_TX) begin
            tx_active_d = 1'b1;
            mod_type_d  = mod_legal(type_d) ? type_d : 3'b000;
        end else begin
            tx_active_d = 1'b0;
        end
        rx_done_d  = rx_pulse_s;
        missed_d   = miss_set_s ? 1'b1 : (clr_flags ? 1'b0 : missed_q);
        collided_d = coll_set_s ? 1'b1 : (clr_flags ? 1'b0 : collided_q);
    end

    assign mod_type  = mod_type_q;
    assign tx_active = tx_active_q;
    assign rx_done   = rx_done_q;
    assign missed    = missed_q;
    assign collided  = collided_q;

endmodule

// File: tb/tb_hi_sim_sched.sv
// Bench for hi_sim_sched: directed scenarios with literal timing checks, then random
// reader traffic compared every cycle against a behavioural model of the scheduler.
module tb_hi_sim_sched;
    localparam int EOF_GAP = 512;
    localparam int BIT_CYC = 128;

    logic        ck = 1'b0;
    logic        nrst = 1'b0;
    logic        rp = 1'b0;
    logic        ar = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  amt = 3'b000;
    logic [11:0] fdt_i = 12'd0;
    logic [9:0]  bits_i = 10'd0;
    logic [2:0]  mod_type;
    logic        tx_active, rx_done, missed, collided;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // model: phase 0 idle, 1 receiving, 2 waiting for fdt, 3 answering
    int         m_phase, m_quiet, m_left;
    logic [2:0] m_type, e_mod;
    logic       e_txa, e_rxd, e_mis, e_col;

    int first_rxd, first_tx, mod_cnt, tx_cnt;

    hi_sim_sched #(.EOF_GAP(EOF_GAP), .BIT_CYC(BIT_CYC)) dut (
        .ck_1356meg  (ck),
        .nrst        (nrst),
        .reader_pause(rp),
        .arm_ready   (ar),
        .arm_mod_type(amt),
        .fdt         (fdt_i),
        .tx_bits     (bits_i),
        .clr_flags   (clr),
        .mod_type    (mod_type),
        .tx_active   (tx_active),
        .rx_done     (rx_done),
        .missed      (missed),
        .collided    (collided)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] t);
        return t inside {3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_quiet = 0; m_left = 0; m_type = 3'b000;
        e_mod = 3'b000; e_txa = 1'b0; e_rxd = 1'b0; e_mis = 1'b0; e_col = 1'b0;
    endtask

    // m_quiet = pause-free cycles since the last pause ended; m_left = answer cycles left
    task automatic model_step();
        int ns;
        bit rxd, sm, sc;
        if (!nrst) begin
            model_reset();
            return;
        end
        ns = m_phase; rxd = 1'b0; sm = 1'b0; sc = 1'b0;
        case (m_phase)
            0: if (rp) begin ns = 1; m_quiet = 0; end
            1: if (rp) m_quiet = 0;
               else begin
                   if (m_quiet == EOF_GAP - 1) begin ns = 2; rxd = 1'b1; end
                   m_quiet++;
               end
            2: if (rp) begin ns = 1; m_quiet = 0; end
               else begin
                   if (m_quiet + 1 >= int'(fdt_i)) begin
                       if (!ar) begin ns = 0; sm = 1'b1; end
                       else if (bits_i == 10'd0) ns = 0;
                       else begin ns = 3; m_left = int'(bits_i) * BIT_CYC; m_type = amt; end
                   end
                   m_quiet++;
               end
            3: if (rp) begin ns = 1; sc = 1'b1; m_quiet = 0; end
               else begin
                   m_left--;
                   if (m_left == 0) ns = 0;
               end
            default: ns = 0;
        endcase
        m_phase = ns;
        e_rxd = rxd;
        e_txa = (ns == 3);
        e_mod = (ns == 3 && legal(m_type)) ? m_type : 3'b000;
        e_mis = sm ? 1'b1 : (clr ? 1'b0 : e_mis);
        e_col = sc ? 1'b1 : (clr ? 1'b0 : e_col);
    endtask

    always @(negedge ck) begin
        if (check_en && nrst) begin
            chk("mod_type", int'(mod_type), int'(e_mod));
            chk("tx_active", int'(tx_active), int'(e_txa));
            chk("rx_done", int'(rx_done), int'(e_rxd));
            chk("missed", int'(missed), int'(e_mis));
            chk("collided", int'(collided), int'(e_col));
        end
    end

    // One carrier cycle: drive the pause input, let the edge sample it, advance the model.
    task automatic cyc(input logic p);
        rp = p;
        @(posedge ck);
        model_step();
        #1;
    endtask

    task automatic pause_for(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    // Index i is the cycle counted from the pause end; outputs seen after its edge.
    task automatic run_quiet(input int n, input logic [2:0] want);
        first_rxd = -1; first_tx = -1; mod_cnt = 0; tx_cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0);
            if (rx_done && first_rxd < 0) first_rxd = i;
            if (tx_active) begin
                if (first_tx < 0) first_tx = i;
                tx_cnt++;
                if (mod_type == want) mod_cnt++;
            end
        end
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        cyc(1'b0);
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_mod", int'(mod_type), 0);
        chk("reset_txa", int'(tx_active), 0);
        chk("reset_flags", int'({rx_done, missed, collided}), 0);
        nrst = 1'b1;
        check_en = 1'b1;

        // normal response: answer starts at 1172, 4 bits of 128 cycles
        fdt_i = 12'd1172; bits_i = 10'd4; ar = 1'b1; amt = 3'b100;
        pause_for(40);
        run_quiet(1800, 3'b100);
        chk("t1_rx_done_cycle", first_rxd, 511);
        chk("t1_tx_entry_cycle", first_tx + 1, 1172);
        chk("t1_mod_cycles", mod_cnt, 512);
        chk("t1_tx_cycles", tx_cnt, 512);
        chk("t1_missed", int'(missed), 0);

        // ARM not ready at expiry
        ar = 1'b0;
        pause_for(40);
        run_quiet(1800, 3'b100);
        chk("t2_tx_cycles", tx_cnt, 0);
        chk("t2_missed", int'(missed), 1);
        clear_flags();
        chk("t2_clr", int'(missed), 0);

        // second pause while waiting restarts the delay from its own end
        ar = 1'b1;
        pause_for(40);
        run_quiet(800, 3'b100);
        chk("t3_first_tx_none", tx_cnt, 0);
        pause_for(10);
        run_quiet(1800, 3'b100);
        chk("t3_rx_done_cycle", first_rxd, 511);
        chk("t3_tx_entry_cycle", first_tx + 1, 1172);

        // collision during bit 2
        pause_for(40);
        run_quiet(1172 + 2 * BIT_CYC + 5, 3'b100);
        chk("t4_in_tx", int'(tx_active), 1);
        cyc(1'b1);
        chk("t4_collided", int'(collided), 1);
        chk("t4_mod_off", int'(mod_type), 0);
        chk("t4_txa_off", int'(tx_active), 0);
        ar = 1'b0;
        run_quiet(1800, 3'b100);
        chk("t4_back_in_rx", first_rxd, 511);
        clear_flags();

        // short fdt: answer begins right after rx_done; illegal type is timed but silent
        ar = 1'b1; fdt_i = 12'd100; bits_i = 10'd2; amt = 3'b001;
        pause_for(40);
        run_quiet(1000, 3'b001);
        chk("t5_rx_done_cycle", first_rxd, 511);
        chk("t5_tx_after_rxd", first_tx, 512);
        chk("t5_mod_cycles", mod_cnt, 256);
        amt = 3'b011;
        pause_for(40);
        run_quiet(1000, 3'b000);
        chk("t5_illegal_tx", tx_cnt, 256);
        chk("t5_illegal_silent", mod_cnt, 256);
        bits_i = 10'd0;
        pause_for(40);
        run_quiet(1000, 3'b000);
        chk("t5_zero_bits_tx", tx_cnt, 0);
        chk("t5_zero_bits_flags", int'({missed, collided}), 0);

        // asynchronous reset mid-answer
        fdt_i = 12'd1172; bits_i = 10'd4; amt = 3'b100;
        pause_for(40);
        run_quiet(1300, 3'b100);
        chk("t6_in_tx", int'(tx_active), 1);
        nrst = 1'b0;
        #1;
        chk("t6_rst_mod", int'(mod_type), 0);
        chk("t6_rst_txa", int'(tx_active), 0);
        model_reset();
        cyc(1'b0);
        nrst = 1'b1;
        run_quiet(5, 3'b100);
        chk("t6_idle_after_rst", tx_cnt, 0);
        pause_for(40);
        run_quiet(1300, 3'b100);
        clr = 1'b1;
        cyc(1'b1);
        clr = 1'b0;
        chk("t6_set_wins", int'(collided), 1);
        clear_flags();
        chk("t6_cleared", int'(collided), 0);

        // random reader traffic against the model
        for (int f = 0; f < 15; f++) begin
            int q;
            fdt_i  = 12'($urandom_range(0, 1400));
            bits_i = 10'($urandom_range(0, 5));
            ar     = ($urandom_range(0, 3) != 0);
            amt    = 3'($urandom_range(0, 7));
            pause_for($urandom_range(1, 50));
            q = $urandom_range(300, 2600);
            for (int i = 0; i < q; i++) begin
                if ($urandom_range(0, 63) == 0) begin
                    amt    = 3'($urandom_range(0, 7));
                    bits_i = 10'($urandom_range(0, 5));
                end
                clr = ($urandom_range(0, 149) == 0);
                cyc($urandom_range(0, 399) == 0);
            end
            clr = 1'b0;
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
